jtkcpu_simctrl: RTL and testbench

- Bus-mapped simulation and interrupt controller that sits on the jtkcpu memory bus, downstream of the CPU address/data/we outputs and upstream of its nmi_n/firq_n/irq_n inputs.
- Decodes writes to a control register and latches pass/fail and end-of-test requests.
- Injects NMI/FIRQ/IRQ after a pseudo-random delay, so interrupt arrival relative to instruction flow varies between runs.
- Synthesizable, so the same CPU test programs run in simulation and on FPGA.

---
 rtl/jtkcpu_simctrl_pkg.sv | 23 ++
 rtl/jtkcpu_simctrl_lfsr.sv | 37 +++
 rtl/jtkcpu_simctrl.sv | 176 +++++++++++++++++
 tb/tb_jtkcpu_simctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtkcpu_simctrl_pkg.sv
// jtkcpu_simctrl_pkg
// Shared types and constants for the jtkcpu simulation/interrupt controller:
// the interrupt-delay FSM state encoding, bit positions inside the control
// register, and the feedback tap mask of the 8-bit LFSR.
package jtkcpu_simctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    FIRE  = 2'd2
  } state_t;

  // Control register bit positions (write side)
  localparam int unsigned BIT_FIN  = 0;
  localparam int unsigned BIT_GOOD = 1;
  localparam int unsigned BIT_IRQ  = 5;
  localparam int unsigned BIT_FIRQ = 6;
  localparam int unsigned BIT_NMI  = 7;

  // x^8 + x^6 + x^5 + x^4 + 1 mapped onto register bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

endpackage

// File: rtl/jtkcpu_simctrl_lfsr.sv
// jtkcpu_simctrl_lfsr
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) with clock enable. Used as the
// pseudo-random source for jt test blocks.
// Ports:
//   clk    in   system clock
//   rst_n  in   synchronous reset, active-low; loads SEED
//   en     in   shift enable
//   q      out  current LFSR state
// Parameters:
//   SEED   reset value, must be non-zero (all-zero is a lock-up state)
module jtkcpu_simctrl_lfsr
  import jtkcpu_simctrl_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [7:0] q
);

  logic [7:0] q_q;
  logic [7:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en) q_d = {q_q[6:0], ^(q_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) q_q <= SEED;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/jtkcpu_simctrl.sv
// jtkcpu_simctrl
// Bus-mapped simulation and interrupt controller for the jtkcpu. A write to
// the control register latches interrupt requests, the pass/fail bit and an
// end-of-test request. Interrupts are driven to the CPU after a delay so that
// their arrival relative to instruction flow can be varied.
//
// Build option: macro JTKCPU_SIMCTRL_RNDDLY_EN
//   defined   - delay is loaded from an LFSR (0 .. 2^DLYW-1 cen2 ticks)
//   undefined - delay is always 0, no LFSR; lines assert exactly 2 cen2
//               ticks after the write
//
// Ports:
//   clk       in   system clock
//   rst_n     in   synchronous reset, active-low
//   cen2      in   CPU clock enable; bus and delay logic advance only when high
//   addr      in   CPU address [23:0]
//   cpu_dout  in   CPU write data
//   we        in   CPU write strobe
//   cs        out  addr[15:12] == BASE (combinational)
//   rd_data   out  read data (combinational)
//   nmi_n     out  NMI to CPU, active-low
//   firq_n    out  FIRQ to CPU, active-low
//   irq_n     out  IRQ to CPU, active-low
//   done      out  end of test, sticky until reset
//   pass      out  last written good bit
//
// Register map (addr[0]):
//   0 write: {nmi, firq, irq, -, -, -, good, fin}
//   0 read : {~nmi_n, ~firq_n, ~irq_n, req!=0, busy, 0, pass, done}
//   1 read : addr[23:16]; writes ignored
module jtkcpu_simctrl
  import jtkcpu_simctrl_pkg::*;
#(
  parameter logic [3:0] BASE    = 4'h1,
  parameter int         DLYW    = 6,
  parameter int         FIN_CNT = 20,
  parameter logic [7:0] SEED    = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen2,
  input  logic [23:0] addr,
  input  logic [7:0]  cpu_dout,
  input  logic        we,
  output logic        cs,
  output logic [7:0]  rd_data,
  output logic        nmi_n,
  output logic        firq_n,
  output logic        irq_n,
  output logic        done,
  output logic        pass
);

  localparam int FINW = $clog2(FIN_CNT + 1);

  state_t            state_q, state_d;
  logic [DLYW-1:0]   dly_q, dly_d;
  logic [2:0]        req_q, req_d;    // {nmi, firq, irq}
  logic [2:0]        low_q, low_d;    // asserted lines, same order
  logic              pass_q, pass_d;
  logic              done_q, done_d;
  logic [FINW-1:0]   fin_q, fin_d;

  logic              wr;
  logic              busy;
  logic [2:0]        fire_set;
  logic [DLYW-1:0]   dly_load;
  logic [7:0]        status;

  // Bits of the bus that this block never decodes
  logic              unused_bits;
  assign unused_bits = ^{addr[11:1], cpu_dout[4:2]};

`ifdef JTKCPU_SIMCTRL_RNDDLY_EN
  logic [7:0] lfsr_q;

  jtkcpu_simctrl_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cen2),
    .q     (lfsr_q)
  );

  assign dly_load = lfsr_q[DLYW-1:0];
`else
  assign dly_load = '0;
`endif

  assign cs   = (addr[15:12] == BASE);
  assign wr   = cs & we & cen2 & ~addr[0];
  assign busy = (state_q != IDLE);

  // FSM next state and delay counter. A write always restarts the delay,
  // whatever state the FSM is in.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    dly_d   = dly_q;
    if (cen2) begin
      case (state_q)
        COUNT: begin
          if (dly_q == '0) state_d = FIRE;
          else             dly_d   = dly_q - DLYW'(1);
        end
        FIRE:    state_d = IDLE;
        default: ;
      endcase
    end
    if (wr) begin
      dly_d   = dly_load;
      state_d = COUNT;
    end
  end

  // Request, line, pass and finish logic
  always_comb begin
    req_d  = req_q;
    pass_d = pass_q;
    fin_d  = fin_q;
    if (wr) begin
      req_d  = cpu_dout[BIT_NMI:BIT_IRQ];
      pass_d = cpu_dout[BIT_GOOD];
    end

    // Lines fall on the FIRE tick; masking with the new request set makes a
    // clearing write win over a simultaneous FIRE and drop the line at once.
    fire_set = (cen2 && state_q == FIRE) ? req_q : 3'b000;
    low_d    = (low_q | fire_set) & req_d;

    // Finish countdown runs on clk; a new request is ignored while counting
    if (fin_q != '0)                     fin_d = fin_q - FINW'(1);
    else if (wr && cpu_dout[BIT_FIN])    fin_d = FIN_CNT[FINW-1:0];

    done_d = done_q | (fin_q == FINW'(1));
  end

  // NOTE: reset is synchronous, sampled only on the clock edge, and all
  // state updates use non-blocking assignments so every flop sees the
  // pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dly_q  <= '0;
      req_q  <= '0;
      low_q  <= '0;
      pass_q <= 1'b0;
      done_q <= 1'b0;
      fin_q  <= '0;
    end else begin
      dly_q  <= dly_d;
      req_q  <= req_d;
      low_q  <= low_d;
      pass_q <= pass_d;
      done_q <= done_d;
      fin_q  <= fin_d;
    end
  end

  assign status  = {low_q, (req_q != 3'b000), busy, 1'b0, pass_q, done_q};
  assign rd_data = !cs     ? 8'h00 :
                   addr[0] ? addr[23:16] : status;

  assign nmi_n  = ~low_q[2];
  assign firq_n = ~low_q[1];
  assign irq_n  = ~low_q[0];
  assign done   = done_q;
  assign pass   = pass_q;

endmodule

// File: tb/tb_jtkcpu_simctrl.sv
// tb_jtkcpu_simctrl
// Self-checking bench for jtkcpu_simctrl. cen2 is a randomly stretched
// enable; expectations come from the block's behavioural rules (tick counts,
// clk counts, register contents) kept in a small model here.
module tb_jtkcpu_simctrl;

  localparam int DLYW    = 6;
  localparam int FIN_CNT = 20;
  localparam int MIN_T   = 2;
`ifdef JTKCPU_SIMCTRL_RNDDLY_EN
  localparam int MAX_T   = (1 << DLYW) + 1;
  localparam int N_IRQ   = 50;
`else
  localparam int MAX_T   = 2;
  localparam int N_IRQ   = 6;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen2 = 1'b0;
  logic [23:0] addr = 24'h001000;
  logic [7:0]  cpu_dout = 8'h00;
  logic        we = 1'b0;
  logic        cs;
  logic [7:0]  rd_data;
  logic        nmi_n, firq_n, irq_n, done, pass;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Model state
  logic       m_pass = 1'b0;
  logic       m_done = 1'b0;

  jtkcpu_simctrl #(
    .BASE    (4'h1),
    .DLYW    (DLYW),
    .FIN_CNT (FIN_CNT),
    .SEED    (8'hA5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cen2     (cen2),
    .addr     (addr),
    .cpu_dout (cpu_dout),
    .we       (we),
    .cs       (cs),
    .rd_data  (rd_data),
    .nmi_n    (nmi_n),
    .firq_n   (firq_n),
    .irq_n    (irq_n),
    .done     (done),
    .pass     (pass)
  );

  always #5 clk = ~clk;

  // cen2 mostly toggles, occasionally holds for an extra clk
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    cen2 <= ($urandom_range(0, 3) != 0) ? ~cen2 : cen2;
  end

  initial begin
    #800us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] low_now();
    return ~{nmi_n, firq_n, irq_n};
  endfunction

  // Wait for the next cen2 tick edge, return #1 after it
  task automatic tick_wait();
    @(negedge clk);
    while (!cen2) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (MAX_T + 4) tick_wait();
  endtask

  // Single write on a cen2 tick; returns #1 after the write edge
  task automatic bus_write(input logic [23:0] a, input logic [7:0] d);
    @(negedge clk);
    while (!cen2) @(negedge clk);
    addr     = a;
    cpu_dout = d;
    we       = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic read_status(input logic [7:0] exp, input string name);
    addr = 24'h001000;
    #1;
    checks++;
    if (rd_data !== exp) begin
      errors++;
      $display("FAIL %s: rd_data=%h required %h", name, rd_data, exp);
    end
  endtask

  // Tick until the asserted lines equal 'expected'; they may only hold
  // 'prior' in between. Returns the tick count from the write edge.
  task automatic wait_fire(input logic [2:0] prior, input logic [2:0] expected,
                           output int ticks);
    ticks = -1;
    for (int k = 1; k <= MAX_T + 2; k++) begin
      tick_wait();
      checks++;
      if (low_now() === expected) begin
        ticks = k;
        break;
      end
      if (low_now() !== prior) begin
        errors++;
        $display("FAIL fire_glitch: lines_low=%b required %b or %b at tick %0d",
                 low_now(), prior, expected, k);
        break;
      end
    end
    checks++;
    if (ticks < MIN_T || ticks > MAX_T) begin
      errors++;
      $display("FAIL fire_delay: ticks=%0d required %0d..%0d", ticks, MIN_T, MAX_T);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({nmi_n, firq_n, irq_n} !== 3'b111) begin
      errors++;
      $display("FAIL reset_lines: got %b required 111", {nmi_n, firq_n, irq_n});
    end
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: got %b required 0", done);
    end
    checks++;
    if (pass !== 1'b0) begin
      errors++;
      $display("FAIL reset_pass: got %b required 0", pass);
    end
    checks++;
    if (cs !== 1'b1) begin
      errors++;
      $display("FAIL reset_cs: got %b required 1", cs);
    end
    read_status(8'h00, "reset_status");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_irq();
    int t;
    int first_t;
    bit differ;
    logic [7:0]  hi;
    logic [10:0] mid;
    logic [2:0]  req;
    logic [23:0] a;
    first_t = -1;
    differ  = 1'b0;
    for (int i = 0; i < N_IRQ; i++) begin
      hi  = 8'($urandom);
      mid = 11'($urandom);
`ifdef JTKCPU_SIMCTRL_RNDDLY_EN
      req = 3'b111;
`else
      req = 3'($urandom_range(1, 7));
`endif
      a = {hi, 4'h1, mid, 1'b0};
      bus_write(a, {req, 5'b00000});
      checks++;
      if (low_now() !== 3'b000) begin
        errors++;
        $display("FAIL irq_early: lines_low=%b required 000", low_now());
      end
      wait_fire(3'b000, req, t);
      if (first_t < 0) first_t = t;
      else if (t != first_t) differ = 1'b1;
      read_status({req, 1'b1, 1'b0, 1'b0, m_pass, m_done}, "irq_status");
      bus_write(a, 8'h00);
      checks++;
      if (low_now() !== 3'b000) begin
        errors++;
        $display("FAIL irq_clear: lines_low=%b required 000", low_now());
      end
    end
`ifdef JTKCPU_SIMCTRL_RNDDLY_EN
    checks++;
    if (!differ) begin
      errors++;
      $display("FAIL irq_random: distinct_delays=1 required >=2");
    end
`endif
  endtask

  task automatic test_add_line();
    int t;
    bus_write(24'h001000, 8'h20);
    wait_fire(3'b000, 3'b001, t);
    bus_write(24'h001000, 8'hA0);
    checks++;
    if (low_now() !== 3'b001) begin
      errors++;
      $display("FAIL add_keeps_irq: lines_low=%b required 001", low_now());
    end
    wait_fire(3'b001, 3'b101, t);
    bus_write(24'h001000, 8'h80);
    checks++;
    if (low_now() !== 3'b100) begin
      errors++;
      $display("FAIL clear_irq_now: lines_low=%b required 100", low_now());
    end
    bus_write(24'h001000, 8'h00);
    checks++;
    if (low_now() !== 3'b000) begin
      errors++;
      $display("FAIL clear_all: lines_low=%b required 000", low_now());
    end
    // Back-to-back: the second write restarts the delay and drops irq
    bus_write(24'h001000, 8'h20);
    tick_wait();
    bus_write(24'h001000, 8'h40);
    checks++;
    if (low_now() !== 3'b000) begin
      errors++;
      $display("FAIL reload_early: lines_low=%b required 000", low_now());
    end
    wait_fire(3'b000, 3'b010, t);
    bus_write(24'h001000, 8'h00);
    settle();
  endtask

  task automatic test_finish();
    int start;
    int rise;
    rise = -1;
    bus_write(24'h001000, 8'h03);
    m_pass = 1'b1;
    start  = cyc;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 && rise < 0) rise = cyc - start;
    end
    bus_write(24'h001000, 8'h03);
    for (int k = 0; k < 40 && rise < 0; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) rise = cyc - start;
    end
    m_done = 1'b1;
    checks++;
    if (rise != FIN_CNT) begin
      errors++;
      $display("FAIL done_latency: clk=%0d required %0d", rise, FIN_CNT);
    end
    checks++;
    if (pass !== 1'b1) begin
      errors++;
      $display("FAIL pass_set: got %b required 1", pass);
    end
    bus_write(24'h001000, 8'h01);
    m_pass = 1'b0;
    checks++;
    if (pass !== 1'b0) begin
      errors++;
      $display("FAIL pass_clear: got %b required 0", pass);
    end
    settle();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_sticky: got %b required 1", done);
    end
    read_status({6'b000000, m_pass, m_done}, "finish_status");
  endtask

  task automatic test_reg1();
    logic [7:0] hi;
    for (int i = 0; i < 4; i++) begin
      hi   = (i == 0) ? 8'h5C : 8'($urandom);
      addr = {hi, 4'h1, 12'h001};
      #1;
      checks++;
      if (rd_data !== hi) begin
        errors++;
        $display("FAIL reg1_read: rd_data=%h required %h", rd_data, hi);
      end
      addr = {hi, 4'h3, 12'h000};
      #1;
      checks++;
      if (cs !== 1'b0 || rd_data !== 8'h00) begin
        errors++;
        $display("FAIL outside_cs: cs=%b rd_data=%h required 0/00", cs, rd_data);
      end
    end
    bus_write(24'h5C1001, 8'hE3);
    bus_write(24'h003000, 8'hE3);
    settle();
    checks++;
    if (low_now() !== 3'b000) begin
      errors++;
      $display("FAIL ignored_write_lines: lines_low=%b required 000", low_now());
    end
    read_status({6'b000000, m_pass, m_done}, "ignored_write_status");
  endtask

  task automatic test_reset_mid();
    bus_write(24'h001000, 8'h21);
    tick_wait();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    m_pass = 1'b0;
    m_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick_wait();
      checks++;
      if (irq_n !== 1'b1) begin
        errors++;
        $display("FAIL reset_mid_irq: irq_n=%b required 1 at tick %0d", irq_n, k);
      end
    end
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_done: got %b required 0", done);
    end
    read_status(8'h00, "reset_mid_status");
  endtask

  initial begin
    test_reset();
    test_irq();
    test_add_line();
    test_finish();
    test_reg1();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
